// File: rtl/router_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | router_pkg : shared router types and constants                        |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
package router_pkg;

  localparam int NUM_OF_PORTS = 5;
  localparam int ARB_CNT_W    = 16;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_priority_picker : round-robin first-set search from a pointer      |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module rr_priority_picker #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx,
  output logic [NUM_REQ-1:0] o_onehot
);

  localparam int C_DBL_W = $clog2(2 * NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_masked;
  logic [C_DBL_W-1:0]   w_pos;

  // Upper copy supplies the wrapped-around candidates below the pointer.
  assign w_dbl = {i_req, i_req};

  for (genvar gi = 0; gi < 2 * NUM_REQ; gi++) begin : g_mask
    assign w_masked[gi] = w_dbl[gi] & (gi >= int'(i_ptr));
  end

  always_comb begin
    o_found = 1'b0;
    w_pos   = '0;
    for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        o_found = 1'b1;
        w_pos   = C_DBL_W'(i);
      end
    end
  end

  assign o_idx    = (w_pos >= C_DBL_W'(NUM_REQ)) ? IDX_W'(w_pos - C_DBL_W'(NUM_REQ))
                                                 : IDX_W'(w_pos);
  assign o_onehot = NUM_REQ'(1) << o_idx;

endmodule
`default_nettype wire

// File: rtl/router_output_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | router_output_arbiter : round-robin wormhole arbiter for one output   |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module router_output_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ = NUM_OF_PORTS,
  parameter int CNT_W   = ARB_CNT_W,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_head,
  input  logic [NUM_REQ-1:0] i_tail,
  input  logic               i_on_off,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_owner,
  output logic               o_busy,
  output logic               o_fire,
  output logic [CNT_W-1:0]   o_pkt_count,
  output logic               o_proto_err
);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_busy;
  logic               r_first_flit;
  logic [CNT_W-1:0]   r_pkt_count;
  logic               r_proto_err;

  logic               w_found;
  logic [IDX_W-1:0]   w_win_idx;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic               w_fire;
  logic               w_err_idle;
  logic               w_err_locked;
  logic [IDX_W-1:0]   w_next_ptr;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req    (i_req & i_head),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_idx    (w_win_idx),
    .o_onehot (w_win_onehot)
  );

  assign w_fire       = (r_state == ARB_LOCKED) & i_req[r_owner] & i_on_off;
  assign w_err_idle   = (r_state == ARB_IDLE) & (|(i_req & ~i_head));
  // A head flit is only legal as the first flit of the locked packet.
  assign w_err_locked = w_fire & i_head[r_owner] & ~r_first_flit;
  assign w_next_ptr   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_first_flit <= 1'b0;
      r_pkt_count  <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_err_idle | w_err_locked) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state      <= ARB_LOCKED;
            r_owner      <= w_win_idx;
            r_grant      <= w_win_onehot;
            r_busy       <= 1'b1;
            r_first_flit <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          if (w_fire) begin
            r_first_flit <= 1'b0;
            if (i_tail[r_owner]) begin
              r_state <= ARB_IDLE;
              r_owner <= '0;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_ptr   <= w_next_ptr;
              if (r_pkt_count != {CNT_W{1'b1}}) begin
                r_pkt_count <= r_pkt_count + 1'b1;
              end
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_grant     = r_grant;
  assign o_owner     = r_owner;
  assign o_busy      = r_busy;
  assign o_fire      = w_fire;
  assign o_pkt_count = r_pkt_count;
  assign o_proto_err = r_proto_err;

endmodule
`default_nettype wire
